// File: rtl/brq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brq_pkg
// Description : Shared types and widths for the branch resolution queue.
// Revision    : 1.0 - initial release
// ============================================================================
package brq_pkg;

    localparam int BRQ_GHR_WIDTH = 8;
    localparam int BRQ_STAT_W    = 16;

    // Default-width form of one in-flight prediction record.
    typedef struct packed {
        logic                     pred_taken;
        logic [BRQ_GHR_WIDTH-1:0] index;
    } brq_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolution_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolution_queue_if
// Description : Allocate / resolve / predictor-update bundle of the queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolution_queue_if
    import brq_pkg::*;
#(
    parameter int GHR_WIDTH = BRQ_GHR_WIDTH
) ();

    logic                 alloc_valid;
    logic                 alloc_pred_taken;
    logic [GHR_WIDTH-1:0] alloc_index;
    logic                 alloc_ready;
    logic                 resolve_valid;
    logic                 resolve_taken;
    logic                 resolve_ready;
    logic                 upd_valid;
    logic                 upd_taken;
    logic [GHR_WIDTH-1:0] upd_index;
    logic                 mispredict;

    modport master (
        output alloc_valid, alloc_pred_taken, alloc_index,
        output resolve_valid, resolve_taken,
        input  alloc_ready, resolve_ready,
        input  upd_valid, upd_taken, upd_index, mispredict
    );

    modport slave (
        input  alloc_valid, alloc_pred_taken, alloc_index,
        input  resolve_valid, resolve_taken,
        output alloc_ready, resolve_ready,
        output upd_valid, upd_taken, upd_index, mispredict
    );

endinterface
`default_nettype wire

// File: rtl/brq_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : brq_sat_counter
// Description : Saturating up-counter with enable, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module brq_sat_counter
    import brq_pkg::*;
#(
    parameter int WIDTH = BRQ_STAT_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    output logic      [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_en && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/branch_resolution_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolution_queue
// Description : In-order in-flight branch tracker; drives predictor updates
//               and squashes wrong-path entries on a misprediction.
//               Optional statistics counters enabled by BRQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolution_queue
    import brq_pkg::*;
#(
    parameter  int DEPTH     = 8,
    parameter  int GHR_WIDTH = BRQ_GHR_WIDTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    branch_resolution_queue_if.slave   bus,
    output logic      [PTR_W:0]        count,
    output logic      [BRQ_STAT_W-1:0] stat_resolved,
    output logic      [BRQ_STAT_W-1:0] stat_mispred
);

    typedef struct packed {
        logic                 pred_taken;
        logic [GHR_WIDTH-1:0] index;
    } entry_t;

    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    entry_t w_head;
    logic   w_alloc_fire;
    logic   w_resolve_fire;
    logic   w_squash;

    assign bus.alloc_ready   = (r_count != C_FULL);
    assign bus.resolve_ready = (r_count != '0);
    assign w_alloc_fire      = bus.alloc_valid && bus.alloc_ready;
    assign w_resolve_fire    = bus.resolve_valid && bus.resolve_ready;
    assign w_head            = r_mem[r_head];
    assign w_squash          = w_resolve_fire && (w_head.pred_taken != bus.resolve_taken);
    assign count             = r_count;

    // Contents carry no reset; validity is defined by r_count alone.
    always_ff @(posedge clk) begin
        if (w_alloc_fire && !w_squash) begin
            r_mem[r_tail] <= '{pred_taken: bus.alloc_pred_taken, index: bus.alloc_index};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            bus.upd_valid  <= 1'b0;
            bus.upd_taken  <= 1'b0;
            bus.upd_index  <= '0;
            bus.mispredict <= 1'b0;
        end else begin
            bus.upd_valid  <= w_resolve_fire;
            bus.mispredict <= w_squash;
            if (w_resolve_fire) begin
                bus.upd_taken <= bus.resolve_taken;
                bus.upd_index <= w_head.index;
                r_head        <= r_head + 1'b1;
            end

            // A mispredict drops every younger entry, including a same-cycle alloc.
            if (w_squash) begin
                r_tail  <= r_head + 1'b1;
                r_count <= '0;
            end else begin
                if (w_alloc_fire) begin
                    r_tail <= r_tail + 1'b1;
                end
                case ({w_alloc_fire, w_resolve_fire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef BRQ_STATS_EN
    brq_sat_counter #(.WIDTH(BRQ_STAT_W)) u_stat_resolved (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_resolve_fire),
        .o_value (stat_resolved)
    );

    brq_sat_counter #(.WIDTH(BRQ_STAT_W)) u_stat_mispred (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_squash),
        .o_value (stat_mispred)
    );
`else
    assign stat_resolved = '0;
    assign stat_mispred  = '0;
`endif

endmodule
`default_nettype wire
